tmds_decoder: RTL



---
 rtl/tmds_pkg.sv | 46 ++++
 rtl/tmds_align_fsm.sv | 118 +++++++++++
 rtl/tmds_decoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token words, alignment FSM states and the
// combinational word decoder used by the receive path.
package tmds_pkg;

    localparam logic [9:0] TOK_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TOK_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TOK_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TOK_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_e;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_word_t;

    function automatic tmds_word_t tmds_decode_word(input logic [9:0] w);
        tmds_word_t r;
        logic [7:0] q;
        r.is_ctrl = 1'b1;
        case (w)
            TOK_CTRL_00: r.ctrl = 2'b00;
            TOK_CTRL_01: r.ctrl = 2'b01;
            TOK_CTRL_10: r.ctrl = 2'b10;
            TOK_CTRL_11: r.ctrl = 2'b11;
            default: begin
                r.is_ctrl = 1'b0;
                r.ctrl    = 2'b00;
            end
        endcase
        // Undo the optional inversion, then the XOR/XNOR transition chain.
        q = w[9] ? ~w[7:0] : w[7:0];
        r.data[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            r.data[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment tracker: counts consecutive control tokens, times out the
// search with bit-slip requests and watches an established lock.
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 32,
    parameter int SEARCH_TIMEOUT = 8192,
    parameter int SLIP_SETTLE    = 16
) (
    input  logic clk_pixel,
    input  logic rst_n,
    input  logic is_ctrl_i,
    output logic locked_o,
    output logic bitslip_o
);

    localparam int RUN_W = $clog2(CTRL_RUN) + 1;
    localparam int TMR_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int SET_W = $clog2(SLIP_SETTLE) + 1;

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

    align_state_e     state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             locked_q, bitslip_q;
    logic             run_full_s;

    assign run_full_s = (run_q == RUN_MAX);

    // Consecutive-token run counter; the input is meaningless around a slip.
    always_comb begin
        run_d = run_q;
        if ((state_q == ST_SLIP) || (state_q == ST_SETTLE)) begin
            run_d = '0;
        end else if (!is_ctrl_i) begin
            run_d = '0;
        end else if (!run_full_s) begin
            run_d = run_q + RUN_W'(1);
        end else begin
            run_d = run_q;
        end
    end

    // Next-state logic; one timer serves as search timer and lock watchdog.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        case (state_q)
            ST_SEARCH: begin
                if (run_full_s) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_SLIP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d  = ST_SEARCH;
                    timer_d  = '0;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_LOCKED: begin
                if (run_full_s) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                timer_d  = '0;
                settle_d = '0;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            timer_q   <= '0;
            settle_q  <= '0;
            locked_q  <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            settle_q  <= settle_d;
            locked_q  <= (state_d == ST_LOCKED);
            bitslip_q <= (state_d == ST_SLIP);
        end
    end

    assign locked_o  = locked_q;
    assign bitslip_o = bitslip_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder: 10-bit word to pixel byte / control value / data
// enable, with word alignment. Optional error counter: TMDS_DECODER_ERR_CNT_EN.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 32,
    parameter int SEARCH_TIMEOUT = 8192,
    parameter int SLIP_SETTLE    = 16
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [9:0]  tmds_in,
    output logic [7:0]  data_out,
    output logic [1:0]  ctrl,
    output logic        data_en,
    output logic        locked,
    output logic        bitslip
`ifdef TMDS_DECODER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    tmds_word_t word_s;
    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [1:0] last_ctrl_q, last_ctrl_d;
    logic       en_q, en_d;

    assign word_s = tmds_decode_word(tmds_in);

    tmds_align_fsm #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_SETTLE    (SLIP_SETTLE)
    ) u_align (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .is_ctrl_i (word_s.is_ctrl),
        .locked_o  (locked),
        .bitslip_o (bitslip)
    );

    // Output next-state; last token is tracked even while unlocked so the
    // first data word after lock already carries the right control value.
    always_comb begin
        data_d      = word_s.data;
        last_ctrl_d = word_s.is_ctrl ? word_s.ctrl : last_ctrl_q;
        if (locked) begin
            ctrl_d = last_ctrl_d;
            en_d   = ~word_s.is_ctrl;
        end else begin
            ctrl_d = 2'b00;
            en_d   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= 8'h00;
            ctrl_q      <= 2'b00;
            last_ctrl_q <= 2'b00;
            en_q        <= 1'b0;
        end else begin
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            last_ctrl_q <= last_ctrl_d;
            en_q        <= en_d;
        end
    end

    assign data_out = data_q;
    assign ctrl     = ctrl_q;
    assign data_en  = en_q;

`ifdef TMDS_DECODER_ERR_CNT_EN
    logic [15:0] err_q, err_d;
    logic        locked_prev_q;

    // Saturating count of slip pulses and lock losses.
    always_comb begin
        if ((bitslip || (locked_prev_q && !locked)) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Error counter and lock-edge history.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            err_q         <= 16'h0000;
            locked_prev_q <= 1'b0;
        end else begin
            err_q         <= err_d;
            locked_prev_q <= locked;
        end
    end

    assign err_count = err_q;
`endif

endmodule
